// File: rtl/ysyx_22040237_mc_ctrl.sv
// Multi-cycle instruction sequencer for the RV64 NPC core: FETCH/EXEC/MEM/WB
// stepping, datapath strobes, bus watchdog halts and cycle/instret counters.
module ysyx_22040237_mc_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_rsp_valid_i,
  input  logic        lsu_rsp_valid_i,
  input  logic        rd_wr_en_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic        ebreak_i,
  input  logic        invalid_inst_i,
  output logic        if_req_o,
  output logic        ir_wr_en_o,
  output logic        lsu_req_o,
  output logic        lsu_we_o,
  output logic        rf_wr_en_o,
  output logic        pc_wr_en_o,
  output logic        busy_o,
  output logic        halt_o,
  output logic [1:0]  halt_code_o,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        rdw_q, rdw_d;
  logic [1:0]  halt_code_q, halt_code_d;
  logic [15:0] wd_q, wd_d;
  logic [63:0] cycle_q, cycle_d;
  logic [63:0] instret_q, instret_d;
  logic        retire;
  logic        active;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    rdw_d       = rdw_q;
    halt_code_d = halt_code_q;
    ir_wr_en_o  = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // A response in the expiry cycle still wins over the timeout.
        if (if_rsp_valid_i) begin
          ir_wr_en_o = 1'b1;
          state_d    = S_EXEC;
        end else if (wd_q == WD_LIMIT) begin
          state_d     = S_HALT;
          halt_code_d = 2'd2;
        end
      end
      S_EXEC: begin
        if (invalid_inst_i || (is_load_i && is_store_i)) begin
          state_d     = S_HALT;
          halt_code_d = 2'd1;
        end else if (ebreak_i) begin
          state_d     = S_HALT;
          halt_code_d = 2'd0;
          retire      = 1'b1;
        end else if (is_load_i || is_store_i) begin
          state_d = S_MEM;
          we_d    = is_store_i;
          rdw_d   = rd_wr_en_i;
        end else begin
          state_d = S_WB;
          rdw_d   = rd_wr_en_i;
        end
      end
      S_MEM: begin
        if (lsu_rsp_valid_i) begin
          state_d = S_WB;
        end else if (wd_q == WD_LIMIT) begin
          state_d     = S_HALT;
          halt_code_d = 2'd3;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    active    = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                (state_q == S_MEM)   || (state_q == S_WB);
    wd_d      = ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM)))
                ? wd_q + 16'd1 : 16'd0;
    cycle_d   = active ? cycle_q + 64'd1 : cycle_q;
    instret_d = retire ? instret_q + 64'd1 : instret_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      rdw_q       <= 1'b0;
      halt_code_q <= 2'd0;
      wd_q        <= 16'd0;
      cycle_q     <= 64'd0;
      instret_q   <= 64'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      rdw_q       <= rdw_d;
      halt_code_q <= halt_code_d;
      wd_q        <= wd_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
    end
  end

  assign if_req_o    = (state_q == S_FETCH);
  assign lsu_req_o   = (state_q == S_MEM);
  assign lsu_we_o    = (state_q == S_MEM) && we_q;
  assign rf_wr_en_o  = (state_q == S_WB) && rdw_q;
  assign pc_wr_en_o  = (state_q == S_WB);
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halt_o      = (state_q == S_HALT);
  assign halt_code_o = halt_code_q;
  assign cycle_cnt_o = cycle_q;
  assign instret_o   = instret_q;

endmodule

// File: doc/ysyx_22040237_mc_ctrl.md
# ysyx_22040237_mc_ctrl

Multi-cycle sequencer for the RV64 NPC core. It steps each instruction through fetch, execute, optional memory access and write-back. It generates the enables for the IR, the PC, the register file and the LSU, and drives the IFU/LSU request handshakes. It halts on `ebreak`, on an invalid instruction, or on a bus timeout, and keeps cycle and instret counters for the simulation harness. It sits between the IFU/LSU bus ports and the decode/execute datapath, and consumes the decoder's classification outputs.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: max wait cycles for an IFU/LSU response before a timeout halt (legal range 2..65535).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_rsp_valid_i`  in  1  instruction word valid on IFU bus.
- `lsu_rsp_valid_i`  in  1  LSU access complete.
- `rd_wr_en_i`  in  1  decoder: instruction writes rd (rd≠x0).
- `is_load_i`  in  1  decoder: load opcode.
- `is_store_i`  in  1  decoder: store opcode.
- `ebreak_i`  in  1  decoder: ebreak.
- `invalid_inst_i`  in  1  decoder: unrecognised instruction.
- `if_req_o`  out  1  IFU fetch request.
- `ir_wr_en_o`  out  1  capture fetched word into IR.
- `lsu_req_o`  out  1  LSU access request.
- `lsu_we_o`  out  1  LSU write (store) qualifier.
- `rf_wr_en_o`  out  1  register-file write strobe.
- `pc_wr_en_o`  out  1  PC update strobe (next-PC from BJP/ALU path).
- `busy_o`  out  1  state not IDLE/HALT.
- `halt_o`  out  1  core halted.
- `halt_code_o`  out  2  0 ebreak, 1 invalid inst, 2 fetch timeout, 3 LSU timeout.
- `cycle_cnt_o`  out  64  active cycles.
- `instret_o`  out  64  retired instructions.

## Operation
- States: IDLE, FETCH, EXEC, MEM, WB, HALT. Reset state IDLE.
- IDLE: unconditional → FETCH.
- FETCH:
  - `if_req_o`=1.
  - On `if_rsp_valid_i`: `ir_wr_en_o`=1 (Mealy, same cycle) → EXEC.
  - Otherwise, when the watchdog reaches TIMEOUT_CYCLES-1 → HALT, code 2.
- EXEC: decoder inputs are sampled, in priority order:
  - `invalid_inst_i`, or `is_load_i` and `is_store_i` both set → HALT, code 1. No retire.
  - `ebreak_i` → HALT, code 0. instret +1.
  - `is_load_i` or `is_store_i` → MEM. Latch `we_q`=`is_store_i`, `rdw_q`=`rd_wr_en_i`.
  - Else → WB. Latch `rdw_q`=`rd_wr_en_i`.
- MEM:
  - `lsu_req_o`=1, `lsu_we_o`=`we_q`.
  - On `lsu_rsp_valid_i` → WB.
  - On watchdog expiry → HALT, code 3.
- WB:
  - `rf_wr_en_o`=`rdw_q`, `pc_wr_en_o`=1.
  - instret +1 → FETCH.
- HALT: absorbing until reset. `halt_o`=1; `halt_code_o` frozen; counters frozen.
- Watchdog: 16-bit counter. It clears on every state change and counts while in FETCH/MEM without a response.
- Counters:
  - `cycle_cnt_o` +1 every cycle in FETCH/EXEC/MEM/WB.
  - Both counters are 64-bit unsigned and wrap modulo 2^64 with no flag.
- Outputs other than `ir_wr_en_o` are Moore decodes of state/latched flags.

## Timing
- Reset (async, immediate): state IDLE. All outputs, `we_q`, `rdw_q`, the watchdog, both counters and `halt_code_o` are 0.
- First FETCH cycle: the second rising edge after `rst` deasserts.
- Latency with zero-wait response (response in the first FETCH/MEM cycle):
  - ALU/branch: 3 cycles (FETCH, EXEC, WB).
  - Load/store: 4 cycles.
  - Each wait cycle adds 1.
- Handshake: `if_req_o`/`lsu_req_o` stay high continuously until the response cycle inclusive, then drop the next cycle. Responses outside FETCH/MEM are ignored.
- Response and watchdog expiry in the same cycle: the response wins and the normal transition occurs.
- Timeout halt happens exactly TIMEOUT_CYCLES cycles after entering FETCH/MEM with no response.
- `rf_wr_en_o` and `pc_wr_en_o` are single-cycle pulses, only in WB.
- `rst` asserted mid-instruction (any state, including mid-handshake): immediate return to IDLE. No write or PC strobe is emitted.

## Test plan
- Reset, then one addi: rsp held high, `rd_wr_en_i`=1 → `if_req_o` high the 2nd cycle after deassert; `ir_wr_en_o` in cycle 2, `rf_wr_en_o`/`pc_wr_en_o` in cycle 4; `instret_o`=1, `cycle_cnt_o`=3.
- Store with 2 LSU wait cycles → `lsu_req_o`=`lsu_we_o`=1 for 3 cycles; `rf_wr_en_o`=0 and `pc_wr_en_o`=1 in WB; 6 active cycles total.
- `ebreak_i` in EXEC → `halt_o`=1, `halt_code_o`=0, `instret_o`+1; later `if_rsp_valid_i` pulses cause no state change.
- `invalid_inst_i`=1 together with `ebreak_i`=1 → `halt_code_o`=1, instret unchanged.
- TIMEOUT_CYCLES=4, fetch never answered → HALT on the 4th FETCH cycle, code 2. Rerun with rsp on the 4th cycle → EXEC, no halt.
- `rst` pulsed during MEM wait → all outputs 0 asynchronously; clean restart; no spurious `rf_wr_en_o`.
